password_enroll: RTL and testbench

// Write side of the stored password: user keys a new code on the 16-button pad twice; on match
// the block presents the 16-bit code with a one-cycle load strobe to the password register

---
 rtl/password_enroll_pkg.sv | 29 ++
 rtl/password_enroll_key_edge_encoder.sv | 44 ++++
 rtl/password_enroll.sv | 183 ++++++++++++++++++
 tb/tb_password_enroll.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/password_enroll_pkg.sv
// Shared definitions for the password enrollment block.
//   - state_t      : enrollment FSM states
//   - DIG_W        : bits per keypad digit (button index 0..15)
//   - PAD_KEYS     : number of one-hot keypad lines
//   - DEF_DIGITS   : default digits per code
//   - DEF_TIMEOUT  : default idle-cycle limit between accepted digits
//   - is_one_hot() : true when exactly one bit of a pad vector is set
package password_enroll_pkg;

  localparam int DIG_W       = 4;
  localparam int PAD_KEYS    = 16;
  localparam int DEF_DIGITS  = 4;
  localparam int DEF_TIMEOUT = 1000000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ENTER1 = 3'd1,
    ST_ENTER2 = 3'd2,
    ST_CHECK  = 3'd3,
    ST_COMMIT = 3'd4,
    ST_FAIL   = 3'd5
  } state_t;

  // v & (v-1) clears the lowest set bit; zero afterwards means a single bit was set.
  function automatic logic is_one_hot(input logic [PAD_KEYS-1:0] v);
    return (v != '0) && ((v & (v - PAD_KEYS'(1))) == '0);
  endfunction

endpackage

// File: rtl/password_enroll_key_edge_encoder.sv
// Keypad press detector and encoder.
// A press is accepted on the cycle where the pad was fully released on the
// previous (enabled) cycle and exactly one button is now down. Chords and
// held buttons never produce a second accept.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : 0 freezes the previous-pad register and suppresses accepts
//   buttons    : one-hot pad lines (already synchronised/debounced)
//   accept     : combinational, high for the cycle a press is taken
//   digit      : index of the pressed button, valid with accept
module key_edge_encoder
  import password_enroll_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [PAD_KEYS-1:0] buttons,
  output logic                accept,
  output logic [DIG_W-1:0]    digit
);

  logic [PAD_KEYS-1:0] prev_p0;

  // Previous-pad register only advances while enabled, so a press made and
  // released entirely during en=0 is never observed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_p0 <= '0;
    end else if (en) begin
      prev_p0 <= buttons;
    end
  end

  // Priority is irrelevant here: digit is only used when buttons is one-hot.
  always_comb begin
    digit = '0;
    for (int i = 0; i < PAD_KEYS; i++) begin
      if (buttons[i]) digit = DIG_W'(i);
    end
  end

  assign accept = en && (prev_p0 == '0) && is_one_hot(buttons);

endmodule

// File: rtl/password_enroll.sv
// Password enrollment: the user keys a new code twice on the 16-button pad.
// When both passes agree the code is presented on pw_out with a one-cycle
// pw_load strobe; a mismatch or an over-long pause aborts with a one-cycle
// err pulse and pw_out keeps its previous value.
// Code format: DIG_W-bit button index per digit, first digit in the MSB nibble.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : 1 = advance, 0 = freeze state/counters, strobes forced low
//   buttons     : one-hot pad lines
//   new_pw_req  : start enrollment (sampled in IDLE only)
//   pw_out      : last committed code, held between commits
//   pw_load     : one-cycle strobe, pw_out is valid
//   busy        : high in any state other than IDLE
//   err         : one-cycle pulse on mismatch or timeout
//   digit_cnt   : digits accepted in the current pass
module password_enroll
  import password_enroll_pkg::*;
#(
  parameter  int DIGITS  = DEF_DIGITS,
  parameter  int TIMEOUT = DEF_TIMEOUT,
  localparam int CNT_W   = $clog2(DIGITS + 1),
  localparam int CODE_W  = DIG_W * DIGITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [PAD_KEYS-1:0] buttons,
  input  logic                new_pw_req,
  output logic [CODE_W-1:0]   pw_out,
  output logic                pw_load,
  output logic                busy,
  output logic                err,
  output logic [CNT_W-1:0]    digit_cnt
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  // Idle counter stops at TIMEOUT instead of wrapping.
  function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] v);
    return (v == TMR_W'(TIMEOUT)) ? v : v + TMR_W'(1);
  endfunction

  state_t             state_q;
  state_t             state_d;
  logic [CODE_W-1:0]  shreg;
  logic [CODE_W-1:0]  first_code;
  logic [TMR_W-1:0]   timer;

  logic               accept;
  logic [DIG_W-1:0]   digit;
  logic [CODE_W-1:0]  shifted;
  logic [CNT_W-1:0]   cnt_inc;
  logic               last_digit;
  logic               timer_hit;

  // FSM side-effect controls
  logic               start;
  logic               take;
  logic               to_enter2;
  logic               tick;
  logic               set_load;
  logic               set_err;
  logic               finish;

  key_edge_encoder u_key (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .buttons (buttons),
    .accept  (accept),
    .digit   (digit)
  );

  assign shifted    = {shreg[CODE_W-DIG_W-1:0], digit};
  assign cnt_inc    = digit_cnt + CNT_W'(1);
  assign last_digit = (cnt_inc == CNT_W'(DIGITS));
  // The cycle that would push the idle count to TIMEOUT is the abort cycle.
  assign timer_hit  = (timer >= TMR_W'(TIMEOUT - 1));
  assign busy       = (state_q != ST_IDLE);

  // ---- state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- next state and per-cycle controls ----
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    take      = 1'b0;
    to_enter2 = 1'b0;
    tick      = 1'b0;
    set_load  = 1'b0;
    set_err   = 1'b0;
    finish    = 1'b0;
    if (en) begin
      case (state_q)
        ST_IDLE: begin
          if (new_pw_req) begin
            state_d = ST_ENTER1;
            start   = 1'b1;
          end
        end
        ST_ENTER1, ST_ENTER2: begin
          // An accepted digit wins over a timeout in the same cycle.
          if (accept) begin
            take = 1'b1;
            if (last_digit) begin
              if (state_q == ST_ENTER1) begin
                state_d   = ST_ENTER2;
                to_enter2 = 1'b1;
              end else begin
                state_d = ST_CHECK;
              end
            end
          end else if (timer_hit) begin
            state_d = ST_FAIL;
            set_err = 1'b1;
          end else begin
            tick = 1'b1;
          end
        end
        ST_CHECK: begin
          if (shreg == first_code) begin
            state_d  = ST_COMMIT;
            set_load = 1'b1;
          end else begin
            state_d = ST_FAIL;
            set_err = 1'b1;
          end
        end
        ST_COMMIT, ST_FAIL: begin
          state_d = ST_IDLE;
          finish  = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // ---- datapath and output registers ----
  // pw_load/err are registered on the transition into COMMIT/FAIL, so they are
  // high exactly while the FSM sits in that state, and drop whenever en=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      first_code <= '0;
      digit_cnt  <= '0;
      timer      <= '0;
      pw_out     <= '0;
      pw_load    <= 1'b0;
      err        <= 1'b0;
    end else begin
      pw_load <= set_load;
      err     <= set_err;
      if (start) begin
        shreg     <= '0;
        digit_cnt <= '0;
        timer     <= '0;
      end else if (take) begin
        shreg <= shifted;
        timer <= '0;
        if (to_enter2) begin
          first_code <= shifted;
          digit_cnt  <= '0;
        end else begin
          digit_cnt <= cnt_inc;
        end
      end else if (tick) begin
        timer <= sat_inc(timer);
      end
      if (set_load) pw_out <= shreg;
      if (finish) digit_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_password_enroll.sv
module tb_password_enroll;

  localparam int DIGITS  = 4;
  localparam int TIMEOUT = 50;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] buttons;
  logic        new_pw_req;
  logic [15:0] pw_out;
  logic        pw_load;
  logic        busy;
  logic        err;
  logic [2:0]  digit_cnt;

  int checks;
  int failures;

  typedef struct {
    bit          is_load;
    logic [15:0] code;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] model_pw;
  bit          pending_idle;

  password_enroll #(.DIGITS(DIGITS), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .buttons    (buttons),
    .new_pw_req (new_pw_req),
    .pw_out     (pw_out),
    .pw_load    (pw_load),
    .busy       (busy),
    .err        (err),
    .digit_cnt  (digit_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT shows a strobe.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pw_load || err) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", {30'd0, pw_load, err}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("pulse_kind_load", 32'(pw_load), 32'(mon_e.is_load));
          chk("pulse_kind_err", 32'(err), 32'(!mon_e.is_load));
          if (mon_e.is_load) begin
            chk("pw_out_on_load", 32'(pw_out), 32'(mon_e.code));
            model_pw = mon_e.code;
          end
        end
        pending_idle = pw_load;
      end else if (pending_idle) begin
        chk("busy_after_load", 32'(busy), 32'd0);
        pending_idle = 1'b0;
      end
      chk("pw_out_hold", 32'(pw_out), 32'(model_pw));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int d, input int hold, input int gap);
    buttons = 16'd1 << d;
    cyc(hold);
    buttons = '0;
    cyc(gap);
  endtask

  // Digit i of a code, counting from the first-keyed (most significant) digit.
  function automatic int dig_of(input logic [15:0] code, input int i);
    return (int'(code) / (1 << (4 * (DIGITS - 1 - i)))) % 16;
  endfunction

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 40) begin
      cyc(1);
      n++;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  task automatic request();
    new_pw_req = 1'b1;
    cyc(1);
    new_pw_req = 1'b0;
    chk("busy_after_req", 32'(busy), 32'd1);
    chk("cnt_after_req", 32'(digit_cnt), 32'd0);
  endtask

  // Reference: two passes agree -> load of that code, otherwise error.
  task automatic enroll(input logic [15:0] a, input logic [15:0] b,
                        input int hold, input int gap);
    request();
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (p == 1 && i == DIGITS - 1) begin
          if (a == b) sb.push_back('{is_load: 1'b1, code: a});
          else        sb.push_back('{is_load: 1'b0, code: 16'h0});
        end
        press(dig_of(p == 0 ? a : b, i), hold, gap);
        if (p == 0)
          chk("cnt_pass1", 32'(digit_cnt), (i == DIGITS - 1) ? 32'd0 : 32'(i + 1));
        else if (i < DIGITS - 1)
          chk("cnt_pass2", 32'(digit_cnt), 32'(i + 1));
      end
    end
    wait_idle("idle_after_enroll");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] a;
    logic [15:0] b;
    checks       = 0;
    failures     = 0;
    model_pw     = '0;
    pending_idle = 1'b0;
    rst_n        = 1'b0;
    en           = 1'b0;
    buttons      = '0;
    new_pw_req   = 1'b0;

    // Reset state
    cyc(3);
    chk("rst_pw_out", 32'(pw_out), 32'd0);
    chk("rst_pw_load", 32'(pw_load), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(digit_cnt), 32'd0);
    rst_n = 1'b1;
    en    = 1'b1;

    // Idle with buttons toggling: nothing happens
    for (int i = 0; i < 20; i++) begin
      buttons = (i % 2 == 0) ? (16'd1 << $urandom_range(0, 15)) : 16'h0;
      cyc(1);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_cnt", 32'(digit_cnt), 32'd0);
    end
    buttons = '0;
    cyc(2);

    // Match
    enroll(16'h3A0F, 16'h3A0F, 1, 1);
    chk("match_pw_out", 32'(pw_out), 32'h3A0F);

    // Mismatch keeps the old code
    enroll(16'h1234, 16'h1235, 1, 1);
    chk("mismatch_pw_out", 32'(pw_out), 32'h3A0F);

    // Filtering: chord ignored, held key counted once
    request();
    buttons = 16'h0003;
    cyc(3);
    buttons = '0;
    cyc(1);
    chk("chord_ignored", 32'(digit_cnt), 32'd0);
    press(7, 10, 1);
    chk("held_once", 32'(digit_cnt), 32'd1);
    press(1, 1, 1);
    press(2, 1, 1);
    press(3, 1, 1);
    chk("filter_pass1_done", 32'(digit_cnt), 32'd0);
    press(7, 1, 1);
    press(1, 1, 1);
    press(2, 1, 1);
    sb.push_back('{is_load: 1'b1, code: 16'h7123});
    press(3, 1, 1);
    wait_idle("filter_idle");

    // Timeout after two digits
    request();
    press(4, 1, 1);
    press(9, 1, 1);
    sb.push_back('{is_load: 1'b0, code: 16'h0});
    n = 0;
    while (!err && n < 80) begin
      cyc(1);
      n++;
    end
    chk("timeout_seen", 32'(err), 32'd1);
    chk("timeout_not_early", 32'(n >= 45), 32'd1);
    chk("timeout_not_late", 32'(n <= 55), 32'd1);
    wait_idle("timeout_idle");
    chk("timeout_pw_out", 32'(pw_out), 32'h7123);

    // en=0 for 100 cycles mid-entry: no timeout, state held, presses unseen
    request();
    press(8, 1, 1);
    press(6, 1, 1);
    en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      buttons = ((i % 10) < 3) ? 16'h0008 : 16'h0;
      cyc(1);
    end
    buttons = '0;
    chk("freeze_cnt", 32'(digit_cnt), 32'd2);
    chk("freeze_busy", 32'(busy), 32'd1);
    chk("freeze_err", 32'(err), 32'd0);
    en = 1'b1;
    cyc(1);
    chk("freeze_resume_cnt", 32'(digit_cnt), 32'd2);
    press(6, 1, 1);
    press(8, 1, 1);
    chk("freeze_pass1_done", 32'(digit_cnt), 32'd0);
    press(8, 1, 1);
    press(6, 1, 1);
    press(6, 1, 1);
    sb.push_back('{is_load: 1'b1, code: 16'h8668});
    press(8, 1, 1);
    wait_idle("freeze_idle");

    // All-zero code is legal
    enroll(16'h0000, 16'h0000, 2, 1);
    chk("zero_code", 32'(pw_out), 32'h0000);

    // Randomized enrollments
    for (int r = 0; r < 10; r++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 2))
        0:       b = a;
        1:       b = a ^ (16'd1 << $urandom_range(0, 15));
        default: b = 16'($urandom);
      endcase
      enroll(a, b, $urandom_range(1, 3), $urandom_range(1, 3));
    end

    // Make sure pw_out is non-zero before the reset test
    enroll(16'hC5E1, 16'hC5E1, 1, 1);

    // Asynchronous reset mid-ENTER2
    request();
    for (int i = 0; i < DIGITS; i++) press(5, 1, 1);
    press(5, 1, 1);
    press(5, 1, 1);
    chk("pre_rst_cnt", 32'(digit_cnt), 32'd2);
    #3;
    rst_n    = 1'b0;
    model_pw = '0;
    #1;
    chk("async_pw_out", 32'(pw_out), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_cnt", 32'(digit_cnt), 32'd0);
    chk("async_load", 32'(pw_load), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    press(5, 1, 1);
    press(5, 1, 1);
    cyc(10);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_pw_out", 32'(pw_out), 32'd0);

    cyc(2);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
